// File: rtl/merge_pass_scheduler.sv
// merge_pass_scheduler: sequences the passes of a merge sort over one read master, the merger tree and one write master
module merge_pass_scheduler #(
    parameter int unsigned NUM_READ_CHANNELS  = 8,
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_XFER_SIZE_WIDTH  = 32,
    parameter int unsigned C_BURST_SIZE_BYTES = 1024
) (
    input  logic                                          aclk,
    input  logic                                          areset,
    input  logic                                          ap_start,
    output logic                                          ap_done,
    output logic                                          busy,
    input  logic [7:0]                                    num_pass,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]                 in_addr_offset,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]                 out_addr_offset,
    input  logic [C_XFER_SIZE_WIDTH-1:0]                  xfer_size_in_bytes,
    input  logic [C_XFER_SIZE_WIDTH-1:0]                  init_run_bytes,
    output logic                                          read_start,
    output logic [NUM_READ_CHANNELS*C_M_AXI_ADDR_WIDTH-1:0] read_addr,
    output logic [C_XFER_SIZE_WIDTH-1:0]                  read_size_in_bytes,
    output logic [NUM_READ_CHANNELS-1:0]                  read_chan_en,
    input  logic                                          single_run_read_done,
    output logic                                          write_start,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]                 write_addr,
    input  logic                                          write_done,
    output logic [7:0]                                    pass_idx,
    output logic                                          result_in_b
);
    localparam int unsigned N  = NUM_READ_CHANNELS;
    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned XW = C_XFER_SIZE_WIDTH;
    localparam int unsigned LG = $clog2(N);

    typedef enum logic [2:0] {IDLE, PASS_INIT, RD_ISSUE, RD_WAIT, WR_WAIT, DONE} state_t;

    state_t          state_q, state_d;
    logic [7:0]      np_q, np_d, pass_q, pass_d;
    logic [AW-1:0]   a_q, a_d, b_q, b_d, xfer_q, xfer_d, run_q, run_d, gbase_q, gbase_d;
    logic [AW-1:0]   span, src_d;
    logic            src_b_q, src_b_d, wr_seen_q, wr_seen_d, result_q, result_d;
    logic            ap_done_q, ap_done_d, busy_q, busy_d, rs_q, rs_d, ws_q, ws_d;
    logic [N*AW-1:0] ra_q, ra_d;
    logic [XW-1:0]   rsz_q, rsz_d;
    logic [N-1:0]    en_q, en_d;
    logic [AW-1:0]   wa_q, wa_d;

    assign ap_done            = ap_done_q;
    assign busy               = busy_q;
    assign read_start         = rs_q;
    assign read_addr          = ra_q;
    assign read_size_in_bytes = rsz_q;
    assign read_chan_en       = en_q;
    assign write_start        = ws_q;
    assign write_addr         = wa_q;
    assign pass_idx           = pass_q;
    assign result_in_b        = result_q;

    // Next-state sequencing plus the registered read/write command values for the state being entered
    always_comb begin
        state_d   = state_q;
        np_d      = np_q;
        a_d       = a_q;
        b_d       = b_q;
        xfer_d    = xfer_q;
        run_d     = run_q;
        gbase_d   = gbase_q;
        src_b_d   = src_b_q;
        pass_d    = pass_q;
        wr_seen_d = wr_seen_q;
        result_d  = result_q;
        span      = run_q << LG;
        case (state_q)
            IDLE: if (ap_start) begin
                result_d = 1'b0;
                pass_d   = 8'd0;
                if (num_pass == 8'd0) begin
                    state_d = DONE;
                end else begin
                    np_d    = num_pass;
                    a_d     = in_addr_offset;
                    b_d     = out_addr_offset;
                    xfer_d  = AW'(xfer_size_in_bytes);
                    run_d   = AW'(init_run_bytes);
                    gbase_d = '0;
                    src_b_d = 1'b0;
                    state_d = PASS_INIT;
                end
            end
            PASS_INIT: begin
                wr_seen_d = write_done;
                state_d   = RD_ISSUE;
            end
            RD_ISSUE: begin
                wr_seen_d = wr_seen_q | write_done;
                state_d   = RD_WAIT;
            end
            RD_WAIT: begin
                wr_seen_d = wr_seen_q | write_done;
                if (single_run_read_done) begin
                    if (gbase_q + span >= xfer_q) begin
                        state_d = WR_WAIT;
                    end else begin
                        gbase_d = gbase_q + span;
                        state_d = RD_ISSUE;
                    end
                end
            end
            WR_WAIT: if (write_done || wr_seen_q) begin
                wr_seen_d = 1'b0;
                if (pass_q == np_q - 8'd1) begin
                    result_d = ~src_b_q;
                    state_d  = DONE;
                end else begin
                    pass_d  = pass_q + 8'd1;
                    src_b_d = ~src_b_q;
                    gbase_d = '0;
                    run_d   = (run_q > (xfer_q >> LG)) ? xfer_q : span;
                    state_d = PASS_INIT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        src_d     = src_b_d ? b_d : a_d;
        ap_done_d = state_q == DONE;
        busy_d    = state_d != IDLE;
        ws_d      = state_d == PASS_INIT;
        wa_d      = ws_d ? (src_b_d ? a_d : b_d) : wa_q;
        rs_d      = state_d == RD_ISSUE;
        rsz_d     = rs_d ? XW'(run_d) : rsz_q;
        ra_d      = ra_q;
        en_d      = en_q;
        for (int c = 0; c < N; c++) begin
            ra_d[c*AW +: AW] = rs_d ? src_d + gbase_d + AW'(c) * run_d : ra_q[c*AW +: AW];
            en_d[c]          = rs_d ? (gbase_d + AW'(c) * run_d) < xfer_d : en_q[c];
        end
    end

    // State, latched configuration and registered outputs
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            np_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            xfer_q    <= '0;
            run_q     <= '0;
            gbase_q   <= '0;
            src_b_q   <= 1'b0;
            pass_q    <= '0;
            wr_seen_q <= 1'b0;
            result_q  <= 1'b0;
            ap_done_q <= 1'b0;
            busy_q    <= 1'b0;
            rs_q      <= 1'b0;
            ra_q      <= '0;
            rsz_q     <= '0;
            en_q      <= '0;
            ws_q      <= 1'b0;
            wa_q      <= '0;
        end else begin
            if (state_q == IDLE && ap_start && num_pass != 8'd0)
                assert (init_run_bytes % XW'(C_BURST_SIZE_BYTES) == '0);
            state_q   <= state_d;
            np_q      <= np_d;
            a_q       <= a_d;
            b_q       <= b_d;
            xfer_q    <= xfer_d;
            run_q     <= run_d;
            gbase_q   <= gbase_d;
            src_b_q   <= src_b_d;
            pass_q    <= pass_d;
            wr_seen_q <= wr_seen_d;
            result_q  <= result_d;
            ap_done_q <= ap_done_d;
            busy_q    <= busy_d;
            rs_q      <= rs_d;
            ra_q      <= ra_d;
            rsz_q     <= rsz_d;
            en_q      <= en_d;
            ws_q      <= ws_d;
            wa_q      <= wa_d;
        end
    end
endmodule

// File: tb/tb_merge_pass_scheduler.sv
// tb_merge_pass_scheduler: randomized checks of the merge pass scheduler against a pass/group list model
module tb_merge_pass_scheduler;
    localparam int N = 8;

    logic            aclk = 1'b0;
    logic            areset, ap_start, ap_done, busy;
    logic [7:0]      num_pass, pass_idx;
    logic [63:0]     in_addr_offset, out_addr_offset, write_addr;
    logic [31:0]     xfer_size_in_bytes, init_run_bytes, read_size_in_bytes;
    logic            read_start, single_run_read_done, write_start, write_done, result_in_b;
    logic [N*64-1:0] read_addr;
    logic [N-1:0]    read_chan_en;
    int              checks = 0;
    int              errors = 0;

    merge_pass_scheduler dut (
        .aclk(aclk), .areset(areset), .ap_start(ap_start), .ap_done(ap_done), .busy(busy),
        .num_pass(num_pass), .in_addr_offset(in_addr_offset), .out_addr_offset(out_addr_offset),
        .xfer_size_in_bytes(xfer_size_in_bytes), .init_run_bytes(init_run_bytes),
        .read_start(read_start), .read_addr(read_addr), .read_size_in_bytes(read_size_in_bytes),
        .read_chan_en(read_chan_en), .single_run_read_done(single_run_read_done),
        .write_start(write_start), .write_addr(write_addr), .write_done(write_done),
        .pass_idx(pass_idx), .result_in_b(result_in_b)
    );

    always #5 aclk = ~aclk;

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({ap_done, busy, read_start, write_start, result_in_b} !== 5'b0) begin
            errors++;
            $display("FAIL %s_strobes got=%b want=00000", tag, {ap_done, busy, read_start, write_start, result_in_b});
        end
        checks++;
        if (read_addr !== '0 || read_chan_en !== '0 || read_size_in_bytes !== '0) begin
            errors++;
            $display("FAIL %s_read_regs got addr=%h en=%h size=%h want all zero", tag, read_addr, read_chan_en, read_size_in_bytes);
        end
        checks++;
        if (write_addr !== '0 || pass_idx !== '0) begin
            errors++;
            $display("FAIL %s_write_regs got waddr=%h pass=%0d want zero", tag, write_addr, pass_idx);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (2) @(negedge aclk);
        check_idle_outputs("reset");
        areset = 1'b0;
    endtask

    task automatic run_job(input logic [7:0] np, input logic [31:0] xf, input logic [31:0] ir,
                           input logic [63:0] a, input logic [63:0] b, input bit early, input bit noise);
        logic [63:0]     src, dst, tmp, run, g, xf64;
        logic [N*64-1:0] av;
        logic [N-1:0]    en;
        logic [63:0]     q_wa[$];
        logic [7:0]      q_wp[$], q_rp[$];
        logic [N*64-1:0] q_ra[$];
        logic [N-1:0]    q_en[$];
        logic [31:0]     q_sz[$];
        bit              dst_is_b, exp_res, done, rd_pend, wr_pend;
        int              rd_cnt, wr_cnt;
        src = a; dst = b; run = {32'b0, ir}; xf64 = {32'b0, xf}; dst_is_b = 1'b1; exp_res = 1'b0;
        for (int p = 0; p < int'(np); p++) begin
            q_wa.push_back(dst);
            q_wp.push_back(8'(p));
            g = 64'd0;
            while (g < xf64) begin
                for (int c = 0; c < N; c++) begin
                    av[c*64 +: 64] = src + g + 64'(c) * run;
                    en[c] = (g + 64'(c) * run) < xf64;
                end
                q_ra.push_back(av); q_en.push_back(en); q_sz.push_back(run[31:0]); q_rp.push_back(8'(p));
                g = g + 64'(N) * run;
            end
            exp_res = dst_is_b;
            tmp = src; src = dst; dst = tmp; dst_is_b = !dst_is_b;
            run = (run * 64'(N) > xf64) ? xf64 : run * 64'(N);
        end
        @(negedge aclk);
        num_pass = np; xfer_size_in_bytes = xf; init_run_bytes = ir;
        in_addr_offset = a; out_addr_offset = b; ap_start = 1'b1;
        done = 0; rd_pend = 0; wr_pend = 0; rd_cnt = 0; wr_cnt = 0;
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            @(negedge aclk);
            single_run_read_done = 1'b0;
            write_done = 1'b0;
            ap_start = noise && !ap_done && ($urandom_range(0, 3) == 0);
            if (noise) begin
                num_pass = 8'($urandom); xfer_size_in_bytes = $urandom; init_run_bytes = $urandom;
                in_addr_offset = {$urandom, $urandom}; out_addr_offset = {$urandom, $urandom};
            end
            if (write_start) begin
                checks++;
                if (q_wa.size() == 0) begin
                    errors++;
                    $display("FAIL extra_write_start got addr=%h want no write_start", write_addr);
                end else begin
                    if (write_addr !== q_wa[0] || pass_idx !== q_wp[0]) begin
                        errors++;
                        $display("FAIL write_cmd got addr=%h pass=%0d want addr=%h pass=%0d", write_addr, pass_idx, q_wa[0], q_wp[0]);
                    end
                    void'(q_wa.pop_front()); void'(q_wp.pop_front());
                end
                wr_pend = 1; wr_cnt = early ? 1 : $urandom_range(0, 12);
            end else if (wr_pend) begin
                if (wr_cnt == 0) begin write_done = 1'b1; wr_pend = 0; end
                else wr_cnt--;
            end
            if (read_start) begin
                checks++;
                if (q_ra.size() == 0) begin
                    errors++;
                    $display("FAIL extra_read_start got addr=%h want no read_start", read_addr);
                end else begin
                    if (read_addr !== q_ra[0] || read_chan_en !== q_en[0] || read_size_in_bytes !== q_sz[0] || pass_idx !== q_rp[0] || busy !== 1'b1) begin
                        errors++;
                        $display("FAIL read_cmd got addr=%h en=%h size=%0d pass=%0d busy=%b want addr=%h en=%h size=%0d pass=%0d busy=1",
                                 read_addr, read_chan_en, read_size_in_bytes, pass_idx, busy, q_ra[0], q_en[0], q_sz[0], q_rp[0]);
                    end
                    void'(q_ra.pop_front()); void'(q_en.pop_front()); void'(q_sz.pop_front()); void'(q_rp.pop_front());
                end
                rd_pend = 1; rd_cnt = $urandom_range(0, 3);
            end else if (rd_pend) begin
                if (rd_cnt == 0) begin single_run_read_done = 1'b1; rd_pend = 0; end
                else rd_cnt--;
            end
            if (ap_done) begin
                done = 1;
                checks++;
                if (result_in_b !== exp_res || busy !== 1'b0 || q_wa.size() != 0 || q_ra.size() != 0) begin
                    errors++;
                    $display("FAIL job_done got result=%b busy=%b left_wr=%0d left_rd=%0d want result=%b busy=0 left 0/0",
                             result_in_b, busy, q_wa.size(), q_ra.size(), exp_res);
                end
            end
        end
        single_run_read_done = 1'b0; write_done = 1'b0; ap_start = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL job_timeout got no ap_done want ap_done within 5000 cycles");
        end
    endtask

    task automatic test_single_group();
        run_job(8'd1, 32'd8192, 32'd1024, 64'h1000, 64'h9000, 1'b0, 1'b0);
    endtask

    task automatic test_multi_pass();
        run_job(8'd2, 32'd65536, 32'd1024, 64'h10_0000, 64'h80_0000, 1'b0, 1'b0);
    endtask

    task automatic test_partial_group();
        run_job(8'd1, 32'd4096, 32'd1024, 64'h2000, 64'hA000, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        run_job(8'd3, 32'd8192, 32'd1024, 64'h4000, 64'hC000, 1'b1, 1'b0);
    endtask

    task automatic test_num_pass_zero();
        @(negedge aclk);
        num_pass = 8'd0; ap_start = 1'b1;
        @(negedge aclk);
        ap_start = 1'b0;
        checks++;
        if ({ap_done, busy, read_start, write_start} !== 4'b0100) begin
            errors++;
            $display("FAIL np0_cycle1 got done/busy/rs/ws=%b want 0100", {ap_done, busy, read_start, write_start});
        end
        @(negedge aclk);
        checks++;
        if ({ap_done, busy, read_start, write_start, result_in_b} !== 5'b10000) begin
            errors++;
            $display("FAIL np0_cycle2 got done/busy/rs/ws/res=%b want 10000", {ap_done, busy, read_start, write_start, result_in_b});
        end
        @(negedge aclk);
        checks++;
        if (ap_done !== 1'b0) begin
            errors++;
            $display("FAIL np0_pulse got ap_done=%b want 0", ap_done);
        end
    endtask

    task automatic test_mid_reset();
        bit seen = 0;
        @(negedge aclk);
        num_pass = 8'd2; xfer_size_in_bytes = 32'd65536; init_run_bytes = 32'd1024;
        in_addr_offset = 64'h3000; out_addr_offset = 64'hF000; ap_start = 1'b1;
        for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
            @(negedge aclk);
            ap_start = 1'b0;
            seen = read_start;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL midreset_wait got no read_start want read_start within 20 cycles");
        end
        @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        check_idle_outputs("midreset");
        areset = 1'b0;
        run_job(8'd2, 32'd16384, 32'd2048, 64'h5_0000, 64'h6_0000, 1'b0, 1'b0);
    endtask

    task automatic test_ignored_inputs();
        run_job(8'd3, 32'd32768, 32'd1024, 64'h7_0000, 64'h9_0000, 1'b0, 1'b1);
    endtask

    task automatic test_random_jobs();
        logic [31:0] ir;
        repeat (6) begin
            ir = 32'd1024 << $urandom_range(0, 2);
            run_job(8'($urandom_range(1, 4)), ir * 32'($urandom_range(1, 12)), ir,
                    {$urandom, $urandom} & ~64'hFFF, {$urandom, $urandom} & ~64'hFFF,
                    1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    initial begin
        areset = 1'b1; ap_start = 1'b0; num_pass = '0; in_addr_offset = '0; out_addr_offset = '0;
        xfer_size_in_bytes = '0; init_run_bytes = '0; single_run_read_done = 1'b0; write_done = 1'b0;
        test_reset();
        test_single_group();
        test_multi_pass();
        test_partial_group();
        test_saturation();
        test_num_pass_zero();
        test_mid_reset();
        test_ignored_inputs();
        test_random_jobs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/merge_pass_scheduler.md
Name: merge_pass_scheduler

Overview:
- Sequences a multi-pass merge sort over one AXI read master, the merger tree and one AXI write master.
- Per pass it:
  - issues one write job covering the whole buffer;
  - issues read groups of NUM_READ_CHANNELS runs each;
  - waits for write completion.
- Between passes it grows the run size by NUM_READ_CHANNELS and ping-pongs the source and destination buffers.
- It replaces hand-sequenced control at top level and drives read_start/read_addr/write_start/write_addr for the read and write masters.

Parameters:
- NUM_READ_CHANNELS, 8, merge fan-in; power of two, ≥2.
- C_M_AXI_ADDR_WIDTH, 64, byte address width.
- C_XFER_SIZE_WIDTH, 32, byte-count width.
- C_BURST_SIZE_BYTES, 1024, minimum run size; init_run_bytes is a multiple of this.

Ports:
- aclk  in  1  single clock for the block.
- areset  in  1  synchronous, active-high reset.
- ap_start  in  1  start pulse; sampled only in IDLE.
- ap_done  out  1  one-cycle pulse after the last pass completes.
- busy  out  1  high from leaving IDLE until ap_done.
- num_pass  in  8  number of passes to run; 0 means no work.
- in_addr_offset  in  ADDR  buffer A base address.
- out_addr_offset  in  ADDR  buffer B base address.
- xfer_size_in_bytes  in  XFER  total data size; a multiple of init_run_bytes.
- init_run_bytes  in  XFER  run size at pass 0.
- read_start  out  1  one-cycle pulse per read group.
- read_addr  out  NUM_READ_CHANNELS×ADDR  per-channel run base address.
- read_size_in_bytes  out  XFER  per-channel run length for the current pass.
- read_chan_en  out  NUM_READ_CHANNELS  channel carries a valid run this group.
- single_run_read_done  in  1  pulse: all enabled channels finished the group.
- write_start  out  1  one-cycle pulse per pass.
- write_addr  out  ADDR  destination base address for the pass.
- write_done  in  1  pulse: the pass's write has fully completed.
- pass_idx  out  8  current pass number.
- result_in_b  out  1  final data is in buffer B; valid when ap_done fires.

Behaviour:
- All inputs sampled on the rising edge of aclk.
- Configuration inputs are latched on the ap_start cycle. Later changes to them are ignored until IDLE.
- Reset values: ap_done=0, busy=0, read_start=0, write_start=0, read_addr=0, read_size_in_bytes=0, read_chan_en=0, write_addr=0, pass_idx=0, result_in_b=0. State = IDLE.
- Reset asserted mid-operation aborts within one cycle to these values. Pending done inputs are discarded.
- FSM states: IDLE, PASS_INIT, RD_ISSUE, RD_WAIT, WR_WAIT, DONE.
- IDLE:
  - On ap_start with num_pass=0: go to DONE, with result_in_b=0.
  - On ap_start otherwise: latch configuration; src=A, dst=B, run=init_run_bytes, pass_idx=0, gbase=0; go to PASS_INIT.
  - ap_start outside IDLE is ignored.
- PASS_INIT: pulse write_start with write_addr=dst; clear the wr_seen flag; go to RD_ISSUE.
- RD_ISSUE (one cycle):
  - Pulse read_start.
  - read_addr[c] = src + gbase + c·run.
  - read_chan_en[c] = (gbase + c·run < xfer).
  - read_size_in_bytes = run.
  - All read outputs are registered and stable from this cycle until the next RD_ISSUE.
  - Go to RD_WAIT.
- RD_WAIT: on single_run_read_done, compute span = NUM_READ_CHANNELS·run.
  - If gbase + span ≥ xfer: go to WR_WAIT.
  - Else: gbase += span; go to RD_ISSUE.
- WR_WAIT: on write_done, or if wr_seen is set, the pass is complete.
  - If pass_idx = num_pass−1: go to DONE.
  - Else: pass_idx++; swap src/dst; gbase=0; run = min(run·NUM_READ_CHANNELS, xfer) (saturates, no overflow); go to PASS_INIT.
- write_done arriving in PASS_INIT, RD_ISSUE or RD_WAIT sets wr_seen. It is consumed in WR_WAIT.
- A single_run_read_done and write_done arriving in the same cycle are both honoured.
- DONE (one cycle): ap_done=1, busy=0 next cycle; result_in_b = (dst of the last pass == B); go to IDLE.
- Arithmetic:
  - Internal products and sums are computed at C_M_AXI_ADDR_WIDTH width.
  - Comparisons against xfer are unsigned.
  - c·run is computed as a shift by log2 of a constant multiplier, or by a multiplier; the choice is free, the result must be exact.
- Stray done pulses in IDLE/DONE are ignored.

Test Plan:
- Single pass, single group:
  - Stimulus: num_pass=1, xfer=8192, init_run=1024, A=0x1000, B=0x9000.
  - Response: one write_start with write_addr=0x9000; one read_start with read_addr[c]=0x1000+c·0x400, all chan_en=1, size=1024.
  - After write_done: ap_done pulses, result_in_b=1.
- Multi-group, multi-pass:
  - Stimulus: xfer=65536, init_run=1024, num_pass=2.
  - Pass 0: 8 read groups, gbase stepping by 8192.
  - Pass 1: src=B, write_addr=A, run=8192, 1 group.
  - Response: ap_done with result_in_b=0.
- Partial group:
  - Stimulus: xfer=4096, init_run=1024, num_pass=1.
  - Response: read_chan_en=0x0F; channels 4–7 disabled.
- Saturation and early write_done:
  - Stimulus: num_pass=3, xfer=8192, init_run=1024, so pass 2 run clamps to 8192; write_done injected during RD_WAIT.
  - Response: chan_en=0x01 in pass 2; no hang; pass_idx reaches 2.
- num_pass=0 and mid-run reset:
  - Stimulus: ap_start with num_pass=0; separately, areset asserted during RD_WAIT.
  - Response: num_pass=0 gives ap_done 2 cycles after ap_start, with no read_start/write_start. Mid-run reset returns all outputs to 0 next cycle, and a new ap_start then restarts from pass 0.
